// File: rtl/leaf_wb_arbiter.sv
// Two-master Wishbone arbiter for the leaf slave port: round-robin on ties,
// bus lock while the owner holds cyc, and a slave-wait timeout that answers with a bus error.
module leaf_wb_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o,
    output logic        to_flag_o,
    input  logic        to_clr_i
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TOERR} state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

    state_t          state, state_nxt;
    logic            last_gnt, last_gnt_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt, to_cnt_inc;
    logic            to_hit;

    // Pure state decode: outputs follow the state register, so reset clears them at once.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_adr_o  = 32'h0;
        s_dat_o  = 32'h0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = 32'h0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = 32'h0;
        grant_o  = 2'b00;
        case (state)
            GRANT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & m0_cyc_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
                m0_dat_o = s_dat_i;
                grant_o  = 2'b01;
            end
            GRANT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & m1_cyc_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
                m1_dat_o = s_dat_i;
                grant_o  = 2'b10;
            end
            TOERR: begin
                // last_gnt still names the owner whose transfer timed out
                grant_o  = last_gnt ? 2'b10 : 2'b01;
                m0_err_o = ~last_gnt;
                m1_err_o = last_gnt;
            end
            default: ;
        endcase
    end

    assign to_cnt_inc = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;
    assign to_hit     = s_stb_o & ~s_ack_i & ~s_err_i & (to_cnt_inc == TO_LIM);

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
                    state_nxt    = GRANT0;
                    last_gnt_nxt = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt    = GRANT1;
                    last_gnt_nxt = 1'b1;
                end
            end
            GRANT0: begin
                if (m0_cyc_i) begin
                    if (to_hit)
                        state_nxt = TOERR;
                end else if (m1_cyc_i) begin
                    state_nxt    = GRANT1;
                    last_gnt_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                if (m1_cyc_i) begin
                    if (to_hit)
                        state_nxt = TOERR;
                end else if (m0_cyc_i) begin
                    state_nxt    = GRANT0;
                    last_gnt_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            TOERR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Each new ownership starts its wait budget from zero.
    always_comb begin
        to_cnt_nxt = to_cnt_inc;
        if (((state_nxt == GRANT0) || (state_nxt == GRANT1)) && (state_nxt != state))
            to_cnt_nxt = '0;
        else if (!s_stb_o || s_ack_i || s_err_i)
            to_cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            to_cnt    <= '0;
            to_flag_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            to_cnt   <= to_cnt_nxt;
            if (to_hit)
                to_flag_o <= 1'b1;
            else if (to_clr_i)
                to_flag_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_leaf_wb_arbiter.sv
// Directed bench for leaf_wb_arbiter: arbitration order, bus lock, timeout error and reset abort.
module tb_leaf_wb_arbiter;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i, s_err_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic        to_flag_o, to_clr_i;

    int n_vec = 0;
    int n_bad = 0;

    leaf_wb_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_dat_i(s_dat_i),
        .grant_o(grant_o), .to_flag_o(to_flag_o), .to_clr_i(to_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks run 2ns later, mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic run_to(input bit ack_at_hit, input bit clr_at_hit);
        m0_cyc_i = 1'b1;
        m0_stb_i = 1'b1;
        m0_adr_i = 32'h0000_0200;
        step();
        repeat (TIMEOUT - 1) step();
        settle();
        check_vec("to_pre_cyc", 32'(s_cyc_o), 32'd1);
        s_ack_i  = ack_at_hit;
        to_clr_i = clr_at_hit;
        step();
        s_ack_i  = 1'b0;
        to_clr_i = 1'b0;
        settle();
        if (ack_at_hit) begin
            check_vec("ack_at_limit_err", 32'(m0_err_o), 32'd0);
            check_vec("ack_at_limit_cyc", 32'(s_cyc_o), 32'd1);
            check_vec("ack_at_limit_flag", 32'(to_flag_o), 32'd0);
        end else begin
            check_vec("toerr_cyc", 32'(s_cyc_o), 32'd0);
            check_vec("toerr_stb", 32'(s_stb_o), 32'd0);
            check_vec("toerr_m0_err", 32'(m0_err_o), 32'd1);
            check_vec("toerr_m0_ack", 32'(m0_ack_o), 32'd0);
            check_vec("toerr_m1_err", 32'(m1_err_o), 32'd0);
            check_vec("toerr_grant", 32'(grant_o), 32'd1);
            check_vec("toerr_flag", 32'(to_flag_o), 32'd1);
        end
        m0_cyc_i = 1'b0;
        m0_stb_i = 1'b0;
        step();
        settle();
        check_vec("after_to_grant", 32'(grant_o), 32'd0);
        check_vec("after_to_err", 32'(m0_err_o), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hF;
        m0_adr_i = 32'h0; m0_dat_i = 32'hA0A0_A0A0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 1; m1_sel_i = 4'h3;
        m1_adr_i = 32'h0000_0300; m1_dat_i = 32'hB1B1_B1B1;
        s_ack_i = 0; s_err_i = 0; s_dat_i = 32'h0; to_clr_i = 0;

        step();
        settle();
        check_vec("rst_grant", 32'(grant_o), 32'd0);
        check_vec("rst_cyc", 32'(s_cyc_o), 32'd0);
        check_vec("rst_flag", 32'(to_flag_o), 32'd0);
        reset_n = 1'b1;
        step();

        // Tie straight out of reset: master 0 first, then direct handover to master 1.
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        settle();
        check_vec("arb_latency", 32'(grant_o), 32'd0);
        step();
        settle();
        check_vec("tie_first_m0", 32'(grant_o), 32'd1);
        s_ack_i = 1; s_dat_i = 32'h1111_0000;
        settle();
        check_vec("tie_m0_ack", 32'(m0_ack_o), 32'd1);
        check_vec("tie_m1_noack", 32'(m1_ack_o), 32'd0);
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        settle();
        check_vec("handover_grant", 32'(grant_o), 32'd2);
        check_vec("handover_adr", s_adr_o, 32'h0000_0300);
        check_vec("handover_we", 32'(s_we_o), 32'd1);
        s_ack_i = 1;
        settle();
        check_vec("m1_ack", 32'(m1_ack_o), 32'd1);
        check_vec("m0_noack", 32'(m0_ack_o), 32'd0);
        step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        settle();
        check_vec("idle_grant", 32'(grant_o), 32'd0);

        // Single master 0 read, slave answers two cycles after strobe.
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_0100;
        step();
        settle();
        check_vec("rd_grant", 32'(grant_o), 32'd1);
        check_vec("rd_stb", 32'(s_stb_o), 32'd1);
        check_vec("rd_adr", s_adr_o, 32'h0000_0100);
        check_vec("rd_sel", 32'(s_sel_o), 32'hF);
        step();
        settle();
        check_vec("rd_wait_ack", 32'(m0_ack_o), 32'd0);
        step();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        settle();
        check_vec("rd_ack", 32'(m0_ack_o), 32'd1);
        check_vec("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        check_vec("rd_m1_ack", 32'(m1_ack_o), 32'd0);
        check_vec("rd_m1_dat", m1_dat_o, 32'h0);
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        s_ack_i = 1;
        settle();
        check_vec("late_ack_m0", 32'(m0_ack_o), 32'd0);
        check_vec("late_ack_m1", 32'(m1_ack_o), 32'd0);
        check_vec("late_ack_grant", 32'(grant_o), 32'd0);
        s_ack_i = 0;

        // Tie after master 0 was last: master 1 wins, locked for 4 beats, then master 0.
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        for (int b = 0; b < 4; b++) begin
            m1_stb_i = 1; s_ack_i = 1;
            settle();
            check_vec("lock_grant", 32'(grant_o), 32'd2);
            check_vec("lock_m1_ack", 32'(m1_ack_o), 32'd1);
            check_vec("lock_m0_ack", 32'(m0_ack_o), 32'd0);
            step();
            m1_stb_i = 0; s_ack_i = 0;
            settle();
            check_vec("lock_gap_grant", 32'(grant_o), 32'd2);
            check_vec("lock_gap_stb", 32'(s_stb_o), 32'd0);
            step();
        end
        m1_cyc_i = 0;
        step();
        settle();
        check_vec("after_lock_grant", 32'(grant_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();

        // Timeout, sticky flag, set-over-clear, clear pulse, ack exactly at the limit.
        run_to(1'b0, 1'b0);
        step();
        settle();
        check_vec("flag_sticky", 32'(to_flag_o), 32'd1);
        run_to(1'b0, 1'b1);
        to_clr_i = 1;
        step();
        to_clr_i = 0;
        settle();
        check_vec("flag_cleared", 32'(to_flag_o), 32'd0);
        run_to(1'b1, 1'b0);

        // Reset asserted mid-transfer clears outputs before the next edge.
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        settle();
        check_vec("pre_rst_stb", 32'(s_stb_o), 32'd1);
        s_ack_i = 1;
        reset_n = 0;
        #1;
        check_vec("arst_cyc", 32'(s_cyc_o), 32'd0);
        check_vec("arst_stb", 32'(s_stb_o), 32'd0);
        check_vec("arst_grant", 32'(grant_o), 32'd0);
        check_vec("arst_m0_ack", 32'(m0_ack_o), 32'd0);
        check_vec("arst_m0_err", 32'(m0_err_o), 32'd0);
        check_vec("arst_adr", s_adr_o, 32'h0);
        step();
        s_ack_i = 0;
        reset_n = 1;
        settle();
        check_vec("rel_idle", 32'(grant_o), 32'd0);
        step();
        settle();
        check_vec("rel_grant", 32'(grant_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/leaf_wb_arbiter.md
LEAF_WB_ARBITER -- requirements
Module: leaf_wb_arbiter

Interface
REQ-001 Parameters: TIMEOUT, default 255, max slave wait cycles before bus error; TO_W, default 8, timeout counter width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 mX_cyc_i, mX_stb_i, mX_we_i  input  1 each  master X (X=0 Caravel host, X=1 leaf core) Wishbone cycle/strobe/write.
REQ-005 mX_sel_i  input  4;  mX_adr_i, mX_dat_i  input  32 each  master X byte select, address, write data.
REQ-006 mX_ack_o, mX_err_o  output  1 each;  mX_dat_o  output  32  master X acknowledge, error, read data.
REQ-007 s_cyc_o, s_stb_o, s_we_o  output  1;  s_sel_o  output  4;  s_adr_o, s_dat_o  output  32  shared slave port.
REQ-008 s_ack_i, s_err_i  input  1;  s_dat_i  input  32  slave response.
REQ-009 grant_o  output  2  one-hot current owner (bit X = master X), 00 when idle.
REQ-010 to_flag_o  output  1  sticky timeout status;  to_clr_i  input  1  synchronous clear pulse.

Function
REQ-011 FSM states IDLE, GRANT0, GRANT1, TOERR; state register only; slave outputs are a combinational mux of the granted master's signals.
REQ-012 IDLE: s_cyc_o = s_stb_o = 0, grant_o = 00, all s_* data/address outputs = 0.
REQ-013 IDLE -> GRANTx on the cycle mX_cyc_i is sampled high; grant_o and s_cyc_o visible the following cycle (1-cycle arbitration latency).
REQ-014 Both cyc high in IDLE: grant the master NOT granted last (round-robin bit last_gnt); last_gnt updates on every grant.
REQ-015 GRANTx held while mX_cyc_i = 1 (bus lock; multi-beat cycles never interrupted).
REQ-016 GRANTx with mX_cyc_i = 0: other master cyc high -> GRANT(other) directly (no idle cycle); else -> IDLE.
REQ-017 Owner receives mX_ack_o = s_ack_i, mX_err_o = s_err_i, mX_dat_o = s_dat_i combinationally; non-owner ack/err forced 0, dat_o forced 0.
REQ-018 s_stb_o = owner stb AND owner cyc; s_cyc_o = owner cyc.
REQ-019 Timeout counter (TO_W bits) clears on entering GRANTx, on s_ack_i or s_err_i, and whenever s_stb_o = 0; increments each cycle s_stb_o = 1 with no ack/err; saturates, never wraps.
REQ-020 Counter reaching TIMEOUT with no ack/err that cycle -> TOERR next cycle.
REQ-021 TOERR (exactly 1 cycle): s_cyc_o = s_stb_o = 0, owner mX_err_o = 1, mX_ack_o = 0, grant_o keeps owner bit; to_flag_o set; next state IDLE.
REQ-022 Ack/err arriving on the same cycle the counter hits TIMEOUT: response wins, no TOERR, flag unchanged.
REQ-023 to_flag_o cleared by to_clr_i = 1; set and clear on the same cycle -> set wins.
REQ-024 Late s_ack_i/s_err_i while IDLE or TOERR is ignored (not routed to any master).

Reset
REQ-025 reset_n = 0 immediately (asynchronously) forces state IDLE, counter 0, last_gnt = 1 (master 0 wins first tie), to_flag_o = 0, grant_o = 00, all outputs 0.
REQ-026 Reset asserted mid-transfer aborts it silently: no ack/err issued to either master; after release, arbitration restarts from IDLE.

Verification
REQ-027 Single master 0 read, slave acks 2 cycles after s_stb_o -> grant_o = 01 one cycle after m0_cyc_i, m0_ack_o pulses with m0_dat_o = s_dat_i (e.g. 0xDEADBEEF), m1_ack_o stays 0.
REQ-028 Both masters raise cyc the first cycle after reset -> master 0 granted first; after m0 drops cyc, grant_o goes 01 -> 10 with no IDLE cycle; repeat both -> order alternates 1,0.
REQ-029 Master 1 locked 4-beat cycle (cyc held, stb per beat) while master 0 requests -> grant_o stays 10 for all 4 acks, then 01.
REQ-030 Slave never acks, TIMEOUT = 255 -> TOERR entered 255 cycles after s_stb_o rises, one-cycle mX_err_o, s_cyc_o low, to_flag_o = 1 until to_clr_i pulse; ack on cycle 255 instead -> no error.
REQ-031 reset_n pulled low while s_stb_o = 1 -> all outputs 0 in the same cycle (before next edge), no ack/err observed; post-release request granted normally.
